// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: operand-select encoding and the
// per-stage producer tracker slot.
package hazard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int FWD_SEL_W  = 2;

   typedef enum logic [FWD_SEL_W-1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } trk_slot_t;

   localparam trk_slot_t TRK_BUBBLE = '0;

   // x0 is hard-wired, so it never has a producer worth forwarding from.
   function automatic logic slot_match(input trk_slot_t slot,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic uses);
      return uses && (rs != '0) && slot.reg_write && (slot.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign count_d = (inc && (count_q != '1)) ? count_q + 1'b1 : count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard controller in front of the ALU operand muxes: registered forwarding
// selects, load-use stall and branch flush. HAZARD_STATS_EN adds stall/flush counters.
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_W,
   parameter int FWD_SEL_WIDTH  = FWD_SEL_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic                      id_uses_rs1,
   input  logic                      id_uses_rs2,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic                      id_reg_write,
   input  logic                      id_mem_read,
   input  logic                      ex_branch_taken,
   output logic [FWD_SEL_WIDTH-1:0]  ex_fwd_a,
   output logic [FWD_SEL_WIDTH-1:0]  ex_fwd_b,
   output logic                      stall,
   output logic                      flush_id,
   output logic                      flush_ex
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]               stat_stalls,
   output logic [31:0]               stat_flushes
`endif
);

   trk_slot_t             ex_t_q, mem_t_q, wb_t_q;
   trk_slot_t             ex_t_d;
   fwd_sel_t              sel_q    [2];
   fwd_sel_t              sel_d    [2];
   logic [REG_ADDR_W-1:0] src_rs   [2];
   logic                  src_uses [2];
   logic                  hit_ex   [2];
   logic                  hit_mem  [2];
   logic                  kill_issue;
   logic                  wb_unused;

   assign src_rs[0]   = REG_ADDR_W'(id_rs1);
   assign src_rs[1]   = REG_ADDR_W'(id_rs2);
   assign src_uses[0] = id_uses_rs1;
   assign src_uses[1] = id_uses_rs2;

   // A producer in EX lands in MEM next cycle, one in MEM lands in WB; the
   // newest producer wins. A load in EX cannot forward yet and stalls instead.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
         assign hit_ex[gi]  = slot_match(ex_t_q,  src_rs[gi], src_uses[gi]);
         assign hit_mem[gi] = slot_match(mem_t_q, src_rs[gi], src_uses[gi]);
         assign sel_d[gi]   = kill_issue                          ? FWD_REG :
                              (hit_ex[gi] && !ex_t_q.mem_read)    ? FWD_MEM :
                              hit_mem[gi]                         ? FWD_WB  :
                                                                    FWD_REG;
      end
   endgenerate

   // A taken branch outranks a load-use hazard: the dependent is killed anyway.
   assign stall      = id_valid && ex_t_q.mem_read && (hit_ex[0] || hit_ex[1])
                       && !ex_branch_taken;
   assign flush_id   = ex_branch_taken;
   assign flush_ex   = ex_branch_taken || stall;
   assign kill_issue = flush_ex || !id_valid;

   always_comb begin
      ex_t_d = TRK_BUBBLE;
      if (!kill_issue) begin
         ex_t_d.rd        = REG_ADDR_W'(id_rd);
         ex_t_d.reg_write = id_reg_write;
         ex_t_d.mem_read  = id_mem_read;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_t_q  <= TRK_BUBBLE;
         mem_t_q <= TRK_BUBBLE;
         wb_t_q  <= TRK_BUBBLE;
         for (int i = 0; i < 2; i++) sel_q[i] <= FWD_REG;
      end else begin
         ex_t_q  <= ex_t_d;
         mem_t_q <= ex_t_q;
         wb_t_q  <= mem_t_q;
         for (int i = 0; i < 2; i++) sel_q[i] <= sel_d[i];
      end
   end

   // The WB producer is covered by register-file write-through, so it only retires here.
   assign wb_unused = ^wb_t_q;

   assign ex_fwd_a = FWD_SEL_WIDTH'(sel_q[0]);
   assign ex_fwd_b = FWD_SEL_WIDTH'(sel_q[1]);

`ifdef HAZARD_STATS_EN
   sat_counter #(.WIDTH(32)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall),
      .count (stat_stalls)
   );

   sat_counter #(.WIDTH(32)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ex_branch_taken),
      .count (stat_flushes)
   );
`else
   // Statistics build option off: no counters.
`endif

endmodule
